// File: rtl/wide_add_seq_if.sv
// Operand/result handshake bundle for wide_add_seq.
// master: operand source and result consumer (drives in_valid, a, b, cin, out_ready).
// slave : the adder (drives in_ready, out_valid, sum, cout, ovf).
interface wide_add_seq_if #(
    parameter int unsigned WORDS = 4
);
    localparam int unsigned W = 16 * WORDS;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/wide_add_seq.sv
// Multi-cycle wide adder: adds a WORDS x 16-bit operand pair one 16-bit slice
// per cycle, LSB slice first, linking slices through a registered carry.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - wide_add_seq_if.slave: in_valid/in_ready/a/b/cin operand handshake,
//          out_valid/out_ready/sum/cout/ovf result handshake
module wide_add_seq #(
    parameter int unsigned WORDS = 4
) (
    input  logic          clk,
    input  logic          rst,
    wide_add_seq_if.slave bus
);
    localparam int unsigned W  = 16 * WORDS;
    localparam int unsigned CW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  sum_q;
    logic [CW-1:0] cnt_q;
    logic          carry_q;
    logic          cout_q;
    logic          ovf_q;
    logic          in_ready_q;
    logic          out_valid_q;

    logic [15:0]   sl_a;
    logic [15:0]   sl_b;
    logic [15:0]   sl_s;
    logic          sl_c;
    logic [8:0]    lo_sum;
    logic [8:0]    hi_sum0;
    logic [8:0]    hi_sum1;
    logic [8:0]    hi_sum;

    // Select the operand slice addressed by the slice counter.
    always_comb begin
        sl_a = '0;
        sl_b = '0;
        for (int unsigned k = 0; k < WORDS; k++) begin
            if (cnt_q == CW'(k)) begin
                sl_a = a_q[16*k +: 16];
                sl_b = b_q[16*k +: 16];
            end
        end
    end

    // 16-bit carry-select slice: upper byte precomputed for both carry values.
    assign lo_sum  = {1'b0, sl_a[7:0]} + {1'b0, sl_b[7:0]} + {8'd0, carry_q};
    assign hi_sum0 = {1'b0, sl_a[15:8]} + {1'b0, sl_b[15:8]};
    assign hi_sum1 = {1'b0, sl_a[15:8]} + {1'b0, sl_b[15:8]} + 9'd1;
    assign hi_sum  = lo_sum[8] ? hi_sum1 : hi_sum0;
    assign sl_s    = {hi_sum[7:0], lo_sum[7:0]};
    assign sl_c    = hi_sum[8];

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        carry_q    <= bus.cin;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= ADD;
                    end
                end
                ADD: begin
                    for (int unsigned k = 0; k < WORDS; k++) begin
                        if (cnt_q == CW'(k)) begin
                            sum_q[16*k +: 16] <= sl_s;
                        end
                    end
                    carry_q <= sl_c;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WORDS - 1)) begin
                        cout_q      <= sl_c;
                        // Signed overflow: like-signed operands, result sign differs.
                        ovf_q       <= (a_q[W-1] == b_q[W-1]) && (sl_s[15] != a_q[W-1]);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_wide_add_seq.sv
// Scoreboard bench for wide_add_seq (WORDS=4): directed operand pairs with
// hand-computed results; a negedge monitor pops and checks every result handshake.
module tb_wide_add_seq;
    localparam int unsigned WORDS = 4;
    localparam int unsigned W     = 16 * WORDS;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t exp_q[$];

    wide_add_seq_if #(.WORDS(WORDS)) bus ();

    wide_add_seq #(.WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o);
        exp_t e;
        e.sum  = s;
        e.cout = c;
        e.ovf  = o;
        return e;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result monitor: every output handshake must match the oldest pending entry.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_result: got sum 0x%0h with no pending operation", bus.sum);
            end else begin
                e = exp_q.pop_front();
                chk("result_sum", bus.sum, e.sum);
                chk("result_cout", W'(bus.cout), W'(e.cout));
                chk("result_ovf", W'(bus.ovf), W'(e.ovf));
            end
        end
    end

    // Present an operand pair until accepted; acc is the cycle of the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input bit push, input exp_t e, output int acc);
        int n = 0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        acc          = -1;
        forever begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) break;
            n++;
            if (n >= 50) break;
        end
        if (n >= 50) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got in_ready=%0b expected 1", bus.in_ready);
            bus.in_valid = 1'b0;
        end else begin
            if (push) exp_q.push_back(e);
            @(posedge clk);
            acc = cyc;
            #1;
            // Scramble inputs after capture; the operation in flight must ignore them.
            bus.in_valid = 1'b0;
            bus.a        = {$urandom, $urandom};
            bus.b        = {$urandom, $urandom};
            bus.cin      = 1'($urandom);
        end
    endtask

    // Wait for the block to drain back to IDLE with no pending result.
    task automatic wait_idle();
        int n = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready === 1'b1 && bus.out_valid === 1'b0 && exp_q.size() == 0) break;
            n++;
            if (n >= 40) break;
        end
        if (n >= 40) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: got in_ready=%0b out_valid=%0b pending=%0d expected 1/0/0",
                     bus.in_ready, bus.out_valid, exp_q.size());
        end
    endtask

    initial begin
        int acc1;
        int acc2;
        int hs;
        int n;
        int seen;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", W'(bus.in_ready), W'(1'b1));
        chk("reset_out_valid", W'(bus.out_valid), W'(1'b0));
        chk("reset_sum", bus.sum, '0);
        chk("reset_cout", W'(bus.cout), W'(1'b0));
        chk("reset_ovf", W'(bus.ovf), W'(1'b0));

        // Full carry ripple plus handshake-to-valid latency.
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1, mk(64'h0, 1'b1, 1'b0), acc1);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (bus.out_valid === 1'b1) break;
        end
        chk("ripple_latency", W'(n), W'(5));
        wait_idle();

        // Signed overflow via cin.
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b1, mk(64'h8000_0000_0000_0000, 1'b0, 1'b1), acc1);
        wait_idle();

        // Inter-slice carries.
        send(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b1, mk(64'h0000_0000_0001_0000, 1'b0, 1'b0), acc1);
        wait_idle();
        send(64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1, mk(64'h0001_0000_0000_0000, 1'b0, 1'b0), acc1);
        wait_idle();

        // Backpressure with a second operand waiting the whole time.
        bus.out_ready = 1'b0;
        send(64'h1111_2222_3333_4444, 64'h1111_1111_1111_1111, 1'b0, 1'b1,
             mk(64'h2222_3333_4444_5555, 1'b0, 1'b0), acc1);
        bus.in_valid = 1'b1;
        bus.a        = 64'h5;
        bus.b        = 64'h7;
        bus.cin      = 1'b1;
        exp_q.push_back(mk(64'hD, 1'b0, 1'b0));
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (bus.out_valid === 1'b1) break;
        end
        chk("bp_latency", W'(n), W'(5));
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_out_valid", W'(bus.out_valid), W'(1'b1));
            chk("bp_in_ready", W'(bus.in_ready), W'(1'b0));
            chk("bp_sum", bus.sum, 64'h2222_3333_4444_5555);
            chk("bp_cout", W'(bus.cout), W'(1'b0));
            chk("bp_ovf", W'(bus.ovf), W'(1'b0));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        hs = cyc;
        @(negedge clk);
        chk("bp_in_ready_after", W'(bus.in_ready), W'(1'b1));
        chk("bp_out_valid_after", W'(bus.out_valid), W'(1'b0));
        @(posedge clk);
        acc2 = cyc;
        #1;
        bus.in_valid = 1'b0;
        chk("bp_accept_gap", W'(acc2 - hs), W'(1));
        wait_idle();

        // Reset during the second ADD cycle discards the operation.
        send(64'h1234_0000_0000_0001, 64'h1, 1'b0, 1'b0, mk(64'h0, 1'b0, 1'b0), acc1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", W'(bus.in_ready), W'(1'b1));
        chk("midrst_out_valid", W'(bus.out_valid), W'(1'b0));
        chk("midrst_sum", bus.sum, '0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen++;
        end
        chk("midrst_no_pulse", W'(seen), W'(0));
        send(64'h1234, 64'h1111, 1'b0, 1'b1, mk(64'h2345, 1'b0, 1'b0), acc1);
        wait_idle();

        // Back-to-back with out_ready high.
        send(64'h1, 64'h2, 1'b0, 1'b1, mk(64'h3, 1'b0, 1'b0), acc1);
        send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b1, mk(64'h0, 1'b1, 1'b1), acc2);
        chk("b2b_accept_gap", W'(acc2 - acc1), W'(6));
        wait_idle();

        chk("pending_results", W'(exp_q.size()), W'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
